// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control unit and its datapath.
// The control unit is the master: it samples the opcode and memory handshake and drives every control line.
interface multicycle_control_if;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle MIPS control FSM with memory wait states and sticky illegal-opcode trap.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter logic [5:0] OP_ADDI     = 6'b001000,
  parameter logic [5:0] OP_J        = 6'b000010,
  parameter int         ENABLE_JUMP = 1
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    nxt = TRAP;
    if (op == OP_RTYPE)                       nxt = EXEC;
    else if (op == OP_LW || op == OP_SW)      nxt = MEMADR;
    else if (op == OP_BEQ)                    nxt = BRANCH;
    else if (op == OP_ADDI)                   nxt = ADDIEX;
    else if (op == OP_J && ENABLE_JUMP != 0)  nxt = JUMP;
    return nxt;
  endfunction

  // The trap flag is sticky: it rises with the transition into TRAP and only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == TRAP);
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        state_d   = decode_next(bus.instr_op);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.instr_op == OP_LW)      state_d = MEMRD;
        else if (bus.instr_op == OP_SW) state_d = MEMWR;
        else                            state_d = TRAP;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_dst       = reg_dst;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.illegal_op    = illegal_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level model expands each instruction into its expected per-cycle steps.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] instr_op = 6'd0;

  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control_if bus_nj ();

  assign bus.mem_ready      = mem_ready;
  assign bus.instr_op       = instr_op;
  assign bus_nj.mem_ready   = mem_ready;
  assign bus_nj.instr_op    = instr_op;

  multicycle_control #(.ENABLE_JUMP(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
  multicycle_control #(.ENABLE_JUMP(0)) dut_nj (.clk(clk), .rst(rst), .bus(bus_nj));

  typedef struct {
    logic       chk;
    logic [3:0] st;
    logic       mr;
    logic       ill;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic model_ill = 1'b0;

  logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
  logic [5:0] bad_ops   [5] = '{6'h3f, 6'h01, 6'h05, 6'h0d, 6'h20};

  // Expected control word straight from the per-state output table of the control unit.
  // Packing: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //          reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2].
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iod = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd9:  begin sa = 1; sb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, psrc};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  // One clock cycle: the DUT should be in state st; drive the inputs seen during that cycle.
  task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] op,
                      input logic r, input logic chk);
    exp_t e;
    @(posedge clk); #1;
    rst = r; mem_ready = mr; instr_op = op;
    if (st == 4'd12) model_ill = 1'b1;
    e.chk = chk; e.st = st; e.mr = mr; e.ill = model_ill;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step(4'd0, rnd_bit(), rnd_op(), 1'b1, 1'b0);
    model_ill = 1'b0;
  endtask

  // Expand one instruction into cycles: fw fetch waits, mw data-memory waits.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(4'd0, 1'b0, rnd_op(), 1'b0, 1'b1);
    step(4'd0, 1'b1, rnd_op(), 1'b0, 1'b1);
    step(4'd1, rnd_bit(), op, 1'b0, 1'b1);
    case (op)
      6'h00: begin
        step(4'd6, rnd_bit(), rnd_op(), 1'b0, 1'b1);
        step(4'd7, rnd_bit(), rnd_op(), 1'b0, 1'b1);
      end
      6'h23: begin
        step(4'd2, rnd_bit(), op, 1'b0, 1'b1);
        for (int i = 0; i < mw; i++) step(4'd3, 1'b0, rnd_op(), 1'b0, 1'b1);
        step(4'd3, 1'b1, rnd_op(), 1'b0, 1'b1);
        step(4'd4, rnd_bit(), rnd_op(), 1'b0, 1'b1);
      end
      6'h2b: begin
        step(4'd2, rnd_bit(), op, 1'b0, 1'b1);
        for (int i = 0; i < mw; i++) step(4'd5, 1'b0, rnd_op(), 1'b0, 1'b1);
        step(4'd5, 1'b1, rnd_op(), 1'b0, 1'b1);
      end
      6'h04: step(4'd8, rnd_bit(), rnd_op(), 1'b0, 1'b1);
      6'h08: begin
        step(4'd9, rnd_bit(), rnd_op(), 1'b0, 1'b1);
        step(4'd10, rnd_bit(), rnd_op(), 1'b0, 1'b1);
      end
      6'h02: step(4'd11, rnd_bit(), rnd_op(), 1'b0, 1'b1);
      default: begin
        for (int i = 0; i < 20; i++) step(4'd12, rnd_bit(), rnd_op(), 1'b0, 1'b1);
        do_reset();
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.chk) begin
        check("state", {12'd0, bus.state}, {12'd0, mon_e.st});
        check("ctrl", {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                       bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                       bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                       bus.pc_source}, exp_ctrl(mon_e.st, mon_e.mr));
        check("illegal_op", {15'd0, bus.illegal_op}, {15'd0, mon_e.ill});
        check("rd_wr_excl", {15'd0, bus.mem_read & bus.mem_write}, 16'd0);
        check("rw_pw_excl", {15'd0, bus.reg_write & bus.pc_write}, 16'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    // Directed instructions from the plan
    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 2, 3);
    run_instr(6'h2b, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h3f, 0, 0);

    // Jump with and without jump support
    do_reset();
    run_instr(6'h02, 0, 0);
    @(negedge clk);
    check("nj_state", {12'd0, bus_nj.state}, 16'd12);
    check("nj_illegal", {15'd0, bus_nj.illegal_op}, 16'd1);
    do_reset();

    // Reset during a data-memory wait of a load
    step(4'd0, 1'b1, rnd_op(), 1'b0, 1'b1);
    step(4'd1, 1'b1, 6'h23, 1'b0, 1'b1);
    step(4'd2, 1'b1, 6'h23, 1'b0, 1'b1);
    step(4'd3, 1'b0, rnd_op(), 1'b0, 1'b1);
    step(4'd3, 1'b0, rnd_op(), 1'b1, 1'b1);
    model_ill = 1'b0;
    run_instr(6'h00, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
      else                           op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK for R-type, lw, sw, beq, addi, j.
- Drives the shared-memory multi-cycle datapath: single memory port, IR, A/B/ALUOut registers, PC.
- Adds to the single-cycle decoder:
  - per-state control sequencing;
  - a memory ready handshake with wait states;
  - illegal-opcode trapping;
  - a parametrised opcode map.
- Every output is fully defined (no X) in every state.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode
- ENABLE_JUMP, 1, 0 = treat OP_J as illegal

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- instr_op  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero
- i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR from memory data
- mem_to_reg  output  1  0 = write ALUOut, 1 = write MDR
- reg_dst  output  1  0 = rt, 1 = rd
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  0 = PC, 1 = A
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct field
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  sticky trap flag
- state  output  4  current state encoding, for debug and verification

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12
- Reset: when rst=1 at a clock edge, state←FETCH and illegal_op←0, regardless of current state (including mid memory wait).
- Outputs are pure functions of state and mem_ready. Default for every output is 0; only the values listed below are asserted.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=1 and pc_write=1 only when mem_ready=1.
  - Hold in FETCH while mem_ready=0; →DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by instr_op:
    - RTYPE→EXEC
    - LW or SW→MEMADR
    - BEQ→BRANCH
    - ADDI→ADDIEX
    - J→JUMP if ENABLE_JUMP=1
    - any other opcode→TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW→MEMRD, SW→MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold while mem_ready=0; →MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; →FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold while mem_ready=0; →FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; →RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; →FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; →ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; →FETCH.
- JUMP: pc_write=1, pc_source=10; →FETCH.
- TRAP:
  - illegal_op←1 on entry.
  - All write enables 0.
  - Stays in TRAP until rst.
- Instruction latency with mem_ready tied 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
  - Each cycle with mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Exclusivity: mem_read and mem_write are never both 1. reg_write is never 1 in the same cycle as pc_write.
- instr_op changes outside DECODE/MEMADR have no effect on sequencing.

Test Plan:
- Reset: from any state, rst=1 for one edge → state=0, illegal_op=0, all write enables 0; next edge with mem_ready=1 → ir_write=1, pc_write=1.
- R-type: mem_ready=1, instr_op=000000 → states 0,1,6,7,0. In state 7: reg_write=1, reg_dst=1. alu_op=10 in state 6.
- lw with waits: instr_op=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD → states 0,0,0,1,2,3,3,3,3,4,0. ir_write asserted exactly once. reg_write=1, mem_to_reg=1 only in state 4.
- sw then beq: sw → 0,1,2,5,0 with mem_write=1, i_or_d=1 in state 5. beq → 0,1,8,0 with pc_write_cond=1, alu_op=01, pc_source=01.
- addi / j: addi → 0,1,9,10,0 with alu_src_b=10, then reg_write=1, reg_dst=0. j (ENABLE_JUMP=1) → 0,1,11,0 with pc_write=1, pc_source=10.
- Illegal and reset mid-op:
  - instr_op=111111 → state 12, illegal_op=1, held for 20 cycles with no write enables.
  - Same result for j with ENABLE_JUMP=0.
  - rst asserted during a MEMRD wait → state 0 next cycle, no reg_write.
